// File: rtl/jesd204_pkg.sv
// Shared JESD204 link-layer types and constants: sequencer states,
// K28.x control characters and the ILAS link-configuration octet array.
package jesd204_pkg;

   typedef enum logic [1:0] {
      CGS  = 2'd0,
      ILAS = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [7:0] COMMA  = 8'hBC;  // K28.5 code-group sync
   localparam logic [7:0] R_CHAR = 8'h1C;  // K28.0 multiframe start
   localparam logic [7:0] A_CHAR = 8'h7C;  // K28.3 multiframe end
   localparam logic [7:0] Q_CHAR = 8'h9C;  // K28.4 config start

   localparam int ILAS_CFG_LEN = 14;

   // Config octets; element n is link-config octet n
   typedef logic [ILAS_CFG_LEN-1:0][7:0] cfg_arr_t;

   // Counter width that never collapses to zero bits
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/ilas_octet_gen.sv
// ILAS octet generator for one lane octet position. Purely combinational:
// given the octet index o within the multiframe and the multiframe number m,
// returns the ILAS octet and its control-character flag.
module ilas_octet_gen
   import jesd204_pkg::*;
#(
   parameter int OPM = 64,  // octets per multiframe
   parameter int OW  = 7,   // width of octet index
   parameter int MW  = 2    // width of multiframe counter
) (
   input  logic [OW-1:0]             o,
   input  logic [MW-1:0]             m,
   input  logic [ILAS_CFG_LEN*8-1:0] cfg,
   output logic [7:0]                octet,
   output logic                      k
);

   cfg_arr_t   cfg_a;
   logic [3:0] ci;

   assign cfg_a = cfg;

   // Priority: R at start, A at end, then config block in multiframe 1, else ramp
   always_comb begin
      octet = 8'(o);
      k     = 1'b0;
      ci    = 4'(o - OW'(2));
      if (o == '0) begin
         octet = R_CHAR;
         k     = 1'b1;
      end else if (o == OW'(OPM - 1)) begin
         octet = A_CHAR;
         k     = 1'b1;
      end else if (m == MW'(1) && o == OW'(1)) begin
         octet = Q_CHAR;
         k     = 1'b1;
      end else if (m == MW'(1) && o >= OW'(2) && o <= OW'(15)) begin
         octet = cfg_a[ci];
      end
   end

endmodule

// File: rtl/cgs_ilas_gen.sv
// Per-lane JESD204 transmit start-up sequencer: sends /K/ commas during CGS,
// enters the 4-multiframe ILAS when SYNC_N is released on an LMFC beat, then
// passes transport data through with one cycle of latency.
// Optional build macro ILAS_SYNC_FILTER_EN: when defined, a resync needs
// SYNC_N low for 4 consecutive cycles; otherwise one low cycle suffices.
module cgs_ilas_gen
   import jesd204_pkg::*;
#(
   parameter int BYTES    = 2,
   parameter int K_FRAMES = 32,
   parameter int F        = 2,
   parameter int ILAS_MF  = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      SYNC_N,
   input  logic                      LMFC,
   input  logic [ILAS_CFG_LEN*8-1:0] CFG,
   input  logic [BYTES*8-1:0]        DI,
   output logic                      DATA_RDY,
   output logic [BYTES*8-1:0]        DO,
   output logic [BYTES-1:0]          K,
   output logic                      ILAS_ACT
);

   localparam int OPM = K_FRAMES * F;
   localparam int BPM = OPM / BYTES;
   localparam int BW  = clog2_min1(BPM);
   localparam int MW  = clog2_min1(ILAS_MF);
   localparam int OW  = $clog2(OPM + 1);

   if ((OPM % BYTES) != 0 || OPM < 18) begin : g_bad_cfg
      $error("cgs_ilas_gen: multiframe length must be a multiple of BYTES and at least 18 octets");
   end

   state_t              st;
   logic [BW-1:0]       b, nb;
   logic [MW-1:0]       m, nm;
   logic                ilas_last;
   logic                resync;
   logic [BYTES*8-1:0]  gen_do;
   logic [BYTES-1:0]    gen_k;

`ifdef ILAS_SYNC_FILTER_EN
   logic [1:0] lo_cnt;

   // Count consecutive low SYNC_N cycles, saturating; any high cycle clears
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         lo_cnt <= '0;
      else if (SYNC_N)
         lo_cnt <= '0;
      else if (lo_cnt != 2'd3)
         lo_cnt <= lo_cnt + 2'd1;
   end

   assign resync = !SYNC_N && (lo_cnt == 2'd3);
`else
   assign resync = !SYNC_N;
`endif

   // Beat/multiframe of the ILAS octets to be loaded into DO at the next edge;
   // outside ILAS this points at beat 0 of multiframe 0 for the CGS exit
   always_comb begin
      nb        = '0;
      nm        = '0;
      ilas_last = (b == BW'(BPM - 1)) && (m == MW'(ILAS_MF - 1));
      if (st == ILAS) begin
         if (b == BW'(BPM - 1)) begin
            nb = '0;
            nm = m + MW'(1);
         end else begin
            nb = b + BW'(1);
            nm = m;
         end
      end
   end

   for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [OW-1:0] o_lane;

      assign o_lane = OW'(OW'(nb) * OW'(BYTES) + OW'(gi));

      ilas_octet_gen #(
         .OPM (OPM),
         .OW  (OW),
         .MW  (MW)
      ) u_gen (
         .o     (o_lane),
         .m     (nm),
         .cfg   (CFG),
         .octet (gen_do[8*gi +: 8]),
         .k     (gen_k[gi])
      );
   end

   // Sequencer FSM with registered lane outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st       <= CGS;
         b        <= '0;
         m        <= '0;
         DO       <= {BYTES{COMMA}};
         K        <= '1;
         DATA_RDY <= 1'b0;
         ILAS_ACT <= 1'b0;
      end else begin
         case (st)
            CGS: begin
               DATA_RDY <= 1'b0;
               if (SYNC_N && LMFC) begin
                  st       <= ILAS;
                  b        <= '0;
                  m        <= '0;
                  DO       <= gen_do;
                  K        <= gen_k;
                  ILAS_ACT <= 1'b1;
               end else begin
                  DO       <= {BYTES{COMMA}};
                  K        <= '1;
                  ILAS_ACT <= 1'b0;
               end
            end
            ILAS: begin
               // On leaving ILAS, DO keeps the last ILAS beat for one cycle
               if (resync) begin
                  st       <= CGS;
                  b        <= '0;
                  m        <= '0;
                  ILAS_ACT <= 1'b0;
               end else if (ilas_last) begin
                  st       <= DATA;
                  b        <= '0;
                  m        <= '0;
                  ILAS_ACT <= 1'b0;
                  DATA_RDY <= 1'b1;
               end else begin
                  b  <= nb;
                  m  <= nm;
                  DO <= gen_do;
                  K  <= gen_k;
               end
            end
            DATA: begin
               // DI is consumed on every DATA cycle, including the resync one
               DO <= DI;
               K  <= '0;
               if (resync) begin
                  st       <= CGS;
                  DATA_RDY <= 1'b0;
               end
            end
            default: begin
               st       <= CGS;
               b        <= '0;
               m        <= '0;
               DO       <= {BYTES{COMMA}};
               K        <= '1;
               DATA_RDY <= 1'b0;
               ILAS_ACT <= 1'b0;
            end
         endcase
      end
   end

endmodule
